prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Receive-side PRBS checker: consumes a word-wide data stream carrying a PRBS sequence produced by the team's Galois-LFSR generator, self-synchronises to it, and reports per-bit errors.
- Runs a SEARCH/LOCKED synchronisation state machine and keeps a saturating bit-error counter for link BER measurement.
- Sits at the far end of a serial/parallel link test path.

Parameters:
- POLY_DEGREE, 7, LFSR degree; state is [POLY_DEGREE:1].
- POLYNOMIAL, PRBS7 (shared package), tap mask [POLY_DEGREE:1].
- DATA_WIDTH, 8, bits per input word, >=1.
- LOCK_COUNT, 4, consecutive error-free words needed to enter LOCKED, >=1.
- UNLOCK_ERRORS, 3, consecutive errored words needed to drop back to SEARCH, >=1.
- ERR_CNT_WIDTH, 32, width of the saturating bit-error counter.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous, active-high reset.
- s_tvalid  in  1  input word valid.
- s_tready  out  1  always 1 out of reset; 0 while arst is asserted.
- s_tdata  in  DATA_WIDTH  received word; bit 0 is the oldest bit in the sequence.
- err_clr  in  1  single-cycle synchronous clear of err_count.
- err_valid  out  1  err_vec qualifier; registered copy of the accept.
- err_vec  out  DATA_WIDTH  per-bit mismatch for the accepted word.
- locked  out  1  FSM is in LOCKED.
- err_count  out  ERR_CNT_WIDTH  bit errors accumulated while LOCKED.

Behaviour:
- Reset values:
  - LFSR state = 0; FSM = SEARCH.
  - locked = 0, err_valid = 0, err_vec = 0, err_count = 0, s_tready = 0.
  - Reset is asynchronous and takes effect mid-word.
- Accept:
  - Occurs when s_tvalid & s_tready.
  - No accept: LFSR state, FSM, run counters and err_vec all hold; err_valid = 0.
- Checker step, bits i = 0..DATA_WIDTH-1 in order, combinational:
  - pred = state[1].
  - e[i] = pred ^ s_tdata[i].
  - state = state >> 1, then XOR with POLYNOMIAL if s_tdata[i] = 1.
  - The checker is self-synchronising: the state is driven by received data. After POLY_DEGREE correct bits, predictions are exact.
- Outputs: err_vec, err_valid and the new state are registered on the accept, so latency is 1 cycle.
- word_err = |e. Run counters are cleared on every FSM transition.
- SEARCH:
  - Clean accepted word: good_run++.
  - Errored accepted word: good_run = 0.
  - On the accept that makes good_run = LOCK_COUNT: go to LOCKED; locked = 1 from the next cycle.
- LOCKED:
  - Errored accepted word: bad_run++.
  - Clean accepted word: bad_run = 0.
  - On the accept that makes bad_run = UNLOCK_ERRORS: go to SEARCH; locked = 0 next cycle.
- err_count:
  - On an accept while LOCKED (including the word that triggers unlock), add popcount(e), saturating at all-ones. It never wraps.
  - err_clr alone sets err_count = 0.
  - err_clr together with an accepted LOCKED word sets err_count = popcount(e): clear first, then add.
  - Words accepted in SEARCH are never counted.
- Run counters saturate at their thresholds. Width is $clog2(threshold+1).

Decomposition:
- Shared package lfsr_pkg holds:
  - polynomial constants (PRBS7, PRBS15, PRBS23, PRBS31);
  - typedef enum logic {SEARCH, LOCKED} prbs_chk_state_t;
  - a popcount function.
- Sub-module prbs_err_counter (saturating add-with-clear counter, parameter WIDTH, inputs inc value/enable/clr) is natural and reusable for the team's other BER monitors.

Test Plan:
- Reset, then a clean PRBS7 stream (DATA_WIDTH=8, seed 7'h7F, s_tvalid always 1) -> err_vec nonzero only for word 0; locked=1 the cycle after word 4 is accepted; err_count stays 0.
- Locked stream with one flipped bit in word 10 -> err_vec shows 3 set bits in total (error bit plus 2 tap echoes) across words 10-11; err_count=3; locked stays 1.
- Locked, then 3 consecutive words of all-ones garbage -> locked=0 the cycle after the 3rd; those 3 words are counted; later garbage words are not; resync and relock after 4 clean words.
- ERR_CNT_WIDTH=4, continuous single-bit errors while locked with UNLOCK_ERRORS set large -> err_count climbs to 15 and holds; err_clr coincident with a word having 2 errors -> err_count=2.
- Random s_tvalid gaps (about 50% duty) on a clean stream -> identical lock timing in accepted words and no errors: state holds across gaps.
- arst pulse while locked and mid-stream -> immediate locked=0, err_count=0, s_tready=0; after release, relocks after 1 errored + 4 clean words.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared Galois-LFSR tap masks, checker state type and popcount helper.
package lfsr_pkg;
  localparam logic [7:1] PRBS7 = 7'h60;
  localparam logic [15:1] PRBS15 = 15'h6000;
  localparam logic [23:1] PRBS23 = 23'h42_0000;
  localparam logic [31:1] PRBS31 = 31'h4800_0000;
  typedef enum logic {SEARCH, LOCKED} prbs_chk_state_t;
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n += 7'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/prbs_err_counter.sv
// prbs_err_counter: saturating add-with-clear counter; clear applies before the add.
module prbs_err_counter #(
  parameter int WIDTH = 32,
  parameter int INC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  output logic [WIDTH-1:0]     cnt_o
);
  localparam int SW = (WIDTH > INC_WIDTH ? WIDTH : INC_WIDTH) + 1;
  logic [WIDTH-1:0] cnt_q, cnt_d, base;
  logic [SW-1:0] sum;
  always_comb begin
    base = clr_i ? '0 : cnt_q;
    sum = SW'(base) + SW'(inc_i);
    cnt_d = !en_i ? base : (|sum[SW-1:WIDTH]) ? '1 : sum[WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver with SEARCH/LOCKED sync FSM
// and a saturating bit-error counter that only counts while LOCKED.
module prbs_checker
  import lfsr_pkg::*;
#(
  parameter int                  POLY_DEGREE   = 7,
  parameter logic [POLY_DEGREE:1] POLYNOMIAL   = PRBS7,
  parameter int                  DATA_WIDTH    = 8,
  parameter int                  LOCK_COUNT    = 4,
  parameter int                  UNLOCK_ERRORS = 3,
  parameter int                  ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic                     err_clr,
  output logic                     err_valid,
  output logic [DATA_WIDTH-1:0]    err_vec,
  output logic                     locked,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRORS + 1);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  prbs_chk_state_t fsm_q, fsm_d;
  logic [POLY_DEGREE:1] lfsr_q, lfsr_d, st;
  logic [DATA_WIDTH-1:0] e, ev_q, ev_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic rdy_q, ev_valid_q, accept, word_err;
  // Feedback comes from the received bit, so the state converges after POLY_DEGREE good bits.
  always_comb begin
    st = lfsr_q;
    e = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      e[i] = st[1] ^ s_tdata[i];
      st = (st >> 1) ^ (s_tdata[i] ? POLYNOMIAL : '0);
    end
  end
  assign accept = s_tvalid & rdy_q;
  assign word_err = |e;
  assign lfsr_d = accept ? st : lfsr_q;
  assign ev_d = accept ? e : ev_q;
  always_comb begin
    fsm_d = fsm_q;
    good_d = good_q;
    bad_d = bad_q;
    if (accept) begin
      if (fsm_q == SEARCH) begin
        good_d = word_err ? '0 : good_q + 1'b1;
        if (good_d == GW'(LOCK_COUNT)) begin
          fsm_d = LOCKED;
          good_d = '0;
          bad_d = '0;
        end
      end else begin
        bad_d = word_err ? bad_q + 1'b1 : '0;
        if (bad_d == BW'(UNLOCK_ERRORS)) begin
          fsm_d = SEARCH;
          good_d = '0;
          bad_d = '0;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      fsm_q <= SEARCH;
      lfsr_q <= '0;
      ev_q <= '0;
      good_q <= '0;
      bad_q <= '0;
      rdy_q <= 1'b0;
      ev_valid_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      lfsr_q <= lfsr_d;
      ev_q <= ev_d;
      good_q <= good_d;
      bad_q <= bad_d;
      rdy_q <= 1'b1;
      ev_valid_q <= accept;
    end
  prbs_err_counter #(.WIDTH(ERR_CNT_WIDTH), .INC_WIDTH(IW)) u_cnt (
    .clk  (clk),
    .arst (arst),
    .en_i (accept & (fsm_q == LOCKED)),
    .clr_i(err_clr),
    .inc_i(IW'(popcount(64'(e)))),
    .cnt_o(err_count)
  );
  assign s_tready = rdy_q;
  assign err_valid = ev_valid_q;
  assign err_vec = ev_q;
  assign locked = fsm_q == LOCKED;
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed scenarios against the PRBS7 checker with hand-derived expectations.
module tb_prbs_checker;
  logic clk = 1'b0, arst, s_tvalid, err_clr;
  logic [7:0] s_tdata;
  logic s_tready, err_valid, locked;
  logic [7:0] err_vec;
  logic [31:0] err_count;
  logic s_tready_s, err_valid_s, locked_s;
  logic [7:0] err_vec_s;
  logic [3:0] err_count_s;
  logic [7:1] g;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .arst(arst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .err_clr(err_clr), .err_valid(err_valid), .err_vec(err_vec), .locked(locked), .err_count(err_count)
  );

  prbs_checker #(.ERR_CNT_WIDTH(4), .UNLOCK_ERRORS(100)) dut_s (
    .clk(clk), .arst(arst), .s_tvalid(s_tvalid), .s_tready(s_tready_s), .s_tdata(s_tdata),
    .err_clr(err_clr), .err_valid(err_valid_s), .err_vec(err_vec_s), .locked(locked_s), .err_count(err_count_s)
  );

  task automatic gen_word(output logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      w[i] = g[1];
      g = (g >> 1) ^ (g[1] ? 7'h60 : 7'h00);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic clr);
    s_tvalid = v;
    s_tdata = d;
    err_clr = clr;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #2;
    arst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    arst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = 8'h00;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_vec++; if (err_valid !== 1'b0) begin n_err++; $display("FAIL reset_err_valid: got %b want 0", err_valid); end
    n_vec++; if (err_vec !== 8'h00) begin n_err++; $display("FAIL reset_err_vec: got %h want 00", err_vec); end
    n_vec++; if (err_count !== 32'd0) begin n_err++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    arst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    n_vec++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL post_reset_tready: got %b want 1", s_tready); end
    n_vec++; if (err_valid !== 1'b0) begin n_err++; $display("FAIL idle_err_valid: got %b want 0", err_valid); end
  endtask

  task automatic test_clean_lock();
    logic [7:0] d;
    g = 7'h7F;
    for (int w = 0; w < 8; w++) begin
      gen_word(d);
      step(1'b1, d, 1'b0);
      n_vec++; if (err_valid !== 1'b1) begin n_err++; $display("FAIL clean_valid w%0d: got %b want 1", w, err_valid); end
      n_vec++; if (err_vec !== (w == 0 ? 8'h7F : 8'h00)) begin n_err++; $display("FAIL clean_err_vec w%0d: got %h want %h", w, err_vec, (w == 0 ? 8'h7F : 8'h00)); end
      n_vec++; if (locked !== (w >= 4)) begin n_err++; $display("FAIL clean_locked w%0d: got %b want %b", w, locked, (w >= 4)); end
      n_vec++; if (err_count !== 32'd0) begin n_err++; $display("FAIL clean_count w%0d: got %0d want 0", w, err_count); end
    end
  endtask

  task automatic test_single_flip();
    logic [7:0] d, ev[5];
    logic [31:0] ec[5];
    ev = '{8'h00, 8'h00, 8'h04, 8'h03, 8'h00};
    ec = '{32'd0, 32'd0, 32'd1, 32'd3, 32'd3};
    for (int w = 0; w < 5; w++) begin
      gen_word(d);
      step(1'b1, (w == 2) ? d ^ 8'h04 : d, 1'b0);
      n_vec++; if (err_vec !== ev[w]) begin n_err++; $display("FAIL flip_err_vec w%0d: got %h want %h", w + 8, err_vec, ev[w]); end
      n_vec++; if (err_count !== ec[w]) begin n_err++; $display("FAIL flip_count w%0d: got %0d want %0d", w + 8, err_count, ec[w]); end
      n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL flip_locked w%0d: got %b want 1", w + 8, locked); end
    end
  endtask

  task automatic test_unlock();
    logic [7:0] din[13], ev[13];
    logic [31:0] ec[13];
    logic lk[13];
    do_reset();
    din = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ev  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    ec  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd7, 32'd15, 32'd23, 32'd23, 32'd23, 32'd23, 32'd23, 32'd23, 32'd23};
    lk  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int w = 0; w < 13; w++) begin
      step(1'b1, din[w], 1'b0);
      n_vec++; if (err_vec !== ev[w]) begin n_err++; $display("FAIL unlock_err_vec w%0d: got %h want %h", w, err_vec, ev[w]); end
      n_vec++; if (err_count !== ec[w]) begin n_err++; $display("FAIL unlock_count w%0d: got %0d want %0d", w, err_count, ec[w]); end
      n_vec++; if (locked !== lk[w]) begin n_err++; $display("FAIL unlock_locked w%0d: got %b want %b", w, locked, lk[w]); end
    end
    step(1'b0, 8'h00, 1'b1);
    n_vec++; if (err_count !== 32'd0) begin n_err++; $display("FAIL clr_alone: got %0d want 0", err_count); end
    n_vec++; if (err_valid !== 1'b0) begin n_err++; $display("FAIL clr_alone_valid: got %b want 0", err_valid); end
  endtask

  task automatic test_saturation();
    logic [7:0] ev[12], din[12];
    logic [3:0] ec[12];
    logic clr[12];
    do_reset();
    din = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h00};
    ev  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hC1, 8'hC1, 8'hC1, 8'hC1, 8'hC1, 8'hC1, 8'h80, 8'h60};
    ec  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15, 4'd15, 4'd2};
    clr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int w = 0; w < 12; w++) begin
      step(1'b1, din[w], clr[w]);
      n_vec++; if (err_vec_s !== ev[w]) begin n_err++; $display("FAIL sat_err_vec w%0d: got %h want %h", w, err_vec_s, ev[w]); end
      n_vec++; if (err_count_s !== ec[w]) begin n_err++; $display("FAIL sat_count w%0d: got %0d want %0d", w, err_count_s, ec[w]); end
      n_vec++; if (locked_s !== (w >= 3)) begin n_err++; $display("FAIL sat_locked w%0d: got %b want %b", w, locked_s, (w >= 3)); end
      n_vec++; if (err_valid_s !== 1'b1) begin n_err++; $display("FAIL sat_valid w%0d: got %b want 1", w, err_valid_s); end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    int acc = 0, cyc = 0;
    do_reset();
    g = 7'h7F;
    while (acc < 8 && cyc < 200) begin
      cyc++;
      if ($urandom_range(0, 1) == 1) begin
        gen_word(d);
        step(1'b1, d, 1'b0);
        n_vec++; if (err_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid a%0d: got %b want 1", acc, err_valid); end
        n_vec++; if (err_vec !== (acc == 0 ? 8'h7F : 8'h00)) begin n_err++; $display("FAIL gap_err_vec a%0d: got %h want %h", acc, err_vec, (acc == 0 ? 8'h7F : 8'h00)); end
        n_vec++; if (locked !== (acc >= 4)) begin n_err++; $display("FAIL gap_locked a%0d: got %b want %b", acc, locked, (acc >= 4)); end
        acc++;
      end else begin
        step(1'b0, 8'($urandom), 1'b0);
        n_vec++; if (err_valid !== 1'b0) begin n_err++; $display("FAIL gap_idle_valid a%0d: got %b want 0", acc, err_valid); end
        n_vec++; if (err_vec !== (acc == 1 ? 8'h7F : 8'h00)) begin n_err++; $display("FAIL gap_hold_vec a%0d: got %h want %h", acc, err_vec, (acc == 1 ? 8'h7F : 8'h00)); end
        n_vec++; if (locked !== (acc >= 5)) begin n_err++; $display("FAIL gap_hold_locked a%0d: got %b want %b", acc, locked, (acc >= 5)); end
      end
    end
    n_vec++; if (acc != 8) begin n_err++; $display("FAIL gap_budget: accepted %0d want 8", acc); end
    n_vec++; if (err_count !== 32'd0) begin n_err++; $display("FAIL gap_count: got %0d want 0", err_count); end
  endtask

  task automatic test_arst();
    logic [7:0] d;
    gen_word(d);
    step(1'b1, d ^ 8'h04, 1'b0);
    n_vec++; if (err_count !== 32'd1) begin n_err++; $display("FAIL pre_arst_count: got %0d want 1", err_count); end
    #3;
    arst = 1'b1;
    #1;
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL arst_locked: got %b want 0", locked); end
    n_vec++; if (err_count !== 32'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", err_count); end
    n_vec++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL arst_tready: got %b want 0", s_tready); end
    n_vec++; if (err_vec !== 8'h00) begin n_err++; $display("FAIL arst_err_vec: got %h want 00", err_vec); end
    @(posedge clk);
    #1;
    arst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    n_vec++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL arst_release_tready: got %b want 1", s_tready); end
    for (int w = 0; w < 5; w++) begin
      gen_word(d);
      step(1'b1, d, 1'b0);
      if (w == 0) begin
        n_vec++; if (err_vec === 8'h00) begin n_err++; $display("FAIL relock_first_err: got %h want nonzero", err_vec); end
      end else begin
        n_vec++; if (err_vec !== 8'h00) begin n_err++; $display("FAIL relock_err_vec w%0d: got %h want 00", w, err_vec); end
      end
      n_vec++; if (locked !== (w == 4)) begin n_err++; $display("FAIL relock_locked w%0d: got %b want %b", w, locked, (w == 4)); end
    end
    n_vec++; if (err_count !== 32'd0) begin n_err++; $display("FAIL relock_count: got %0d want 0", err_count); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_flip();
    test_unlock();
    test_saturation();
    test_gaps();
    test_arst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
